sentinel_mem_writer: RTL
========================

# sentinel_mem_writer

Write side of the team's zero-terminated memory convention. It accepts a stream of words over a valid/ready handshake and stores them at consecutive addresses from 0. It then writes a zero sentinel after the last word, so a downstream sequential reader can walk the memory until it hits 0. A registered read port exposes the stored contents to that reader.

## Interface
- DEPTH, 11, number of memory entries; the last entry is always reserved for the sentinel
- DATA_W, 32, word width
- ADDR_W, 4, address width; must satisfy 2**ADDR_W >= DEPTH
- clk  input  1  single clock, rising edge
- rst  input  1  asynchronous, active-high reset
- clear  input  1  synchronous restart of a fill; memory contents untouched
- in_valid  input  1  producer has a word
- in_ready  output  1  block can accept a word
- in_data  input  DATA_W  word to store
- in_last  input  1  marks the final word of the stream
- rd_addr  input  ADDR_W  read address
- rd_data  output  DATA_W  registered read data
- count  output  ADDR_W  number of words stored, excluding the sentinel
- done  output  1  fill complete and sentinel written
- overflow  output  1  stream was truncated because memory filled

## Operation
- Accept means in_valid && in_ready on a rising edge.
- States:
  - FILL: in_ready=1 while wr_ptr < DEPTH-1.
  - TERM: in_ready=0; writes the sentinel.
  - DONE: in_ready=0, done=1.
- FILL, on accept:
  - mem[wr_ptr] <= in_data; wr_ptr++; count++.
  - If in_data == 0: the word is itself the sentinel. Stay on the written address, do not increment count, go to DONE.
  - Else if in_last: go to TERM.
  - Else if wr_ptr+1 == DEPTH-1: set overflow=1 and go to TERM.
  - Otherwise stay in FILL.
- TERM: mem[wr_ptr] <= 0, then go to DONE. Lasts exactly one cycle.
- DONE: hold until clear or rst. Further in_valid is ignored, with no writes.
- clear (any state): next state FILL, wr_ptr=0, count=0, done=0, overflow=0. clear takes priority over a same-cycle accept; that word is dropped and not written.
- Read port:
  - rd_data <= mem[rd_addr] every cycle.
  - rd_addr >= DEPTH returns 0.
  - On a same-address write and read in the same cycle, rd_data returns the old contents.
- count saturates by construction at DEPTH-1.
- Arithmetic is unsigned. The zero test is an exact compare of all DATA_W bits.

## Timing
- Reset values:
  - state FILL, wr_ptr 0, count 0, done 0, overflow 0, rd_data 0.
  - in_ready is forced 0 while rst is high; it goes to 1 on the first cycle after deassertion.
- Memory is not reset; it is undefined until written.
- in_ready depends on registered state and wr_ptr only, with no combinational path from in_valid.
- Throughput: one word per cycle in FILL.
- Sentinel timing:
  - With in_last accepted at cycle N: sentinel written at edge N+1, done=1 from N+2.
  - With zero data accepted at cycle N: done=1 from N+1.
- Read latency: 1 cycle from rd_addr to rd_data.
- rst asserted mid-fill: all state returns to reset values immediately. Words already written remain in memory, but no sentinel is guaranteed.

## Test plan
- Reset, then stream 1,2,3 with in_last on 3:
  - count=3, mem[0..3] = 1,2,3,0.
  - done rises 2 cycles after the last accept, overflow=0.
  - Reads of addresses 0..3 return 1,2,3,0 one cycle later.
- Stream 0..9 in order:
  - The first word 0 is taken as the sentinel: done one cycle later, count=0, mem[0]=0.
- Stream 1..12 with no in_last:
  - Words 1..10 accepted; in_ready falls after the 10th word.
  - overflow=1, mem[10]=0, count=10, words 11 and 12 never accepted.
- Producer drops in_valid every other cycle while sending 5,6,7(last): no lost or duplicated words; mem[0..3] = 5,6,7,0.
- Handshake and clear:
  - In DONE, hold in_valid=1 with data 9: memory is unchanged and in_ready stays 0.
  - Assert clear together with a valid word 4: the word is dropped, and the next fill starts at address 0 with done=0.
- Reset mid-fill:
  - Assert rst after 2 accepted words: in_ready=0 and done=0 while reset is held, count=0 after release.
  - A new stream 8(last) gives mem[0..1] = 8,0.
- Boundary read: rd_addr=15 returns 0.

Source files
------------

// File: rtl/sentinel_mem_writer_if.sv
// sentinel_mem_writer_if
//   Groups the producer handshake, the restart strobe, the reader port and the
//   fill status of sentinel_mem_writer into one bundle.
//
//   Handshake: a word transfers on a rising clk edge where in_valid && in_ready.
//   The producer keeps in_data/in_last stable while in_valid is high and not yet
//   accepted; in_ready never depends on in_valid.
//
//   Signals
//     clear     master->slave  synchronous restart of a fill
//     in_valid  master->slave  producer has a word
//     in_ready  slave->master  block can accept a word
//     in_data   master->slave  word to store
//     in_last   master->slave  final word of the stream
//     rd_addr   master->slave  read address
//     rd_data   slave->master  registered read data (1-cycle latency)
//     count     slave->master  words stored, excluding the sentinel
//     done      slave->master  fill complete and sentinel present
//     overflow  slave->master  stream truncated because memory filled
interface sentinel_mem_writer_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 4
) ();
    logic              clear;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              in_last;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic [ADDR_W-1:0] count;
    logic              done;
    logic              overflow;

    modport master (
        output clear, in_valid, in_data, in_last, rd_addr,
        input  in_ready, rd_data, count, done, overflow
    );

    modport slave (
        input  clear, in_valid, in_data, in_last, rd_addr,
        output in_ready, rd_data, count, done, overflow
    );
endinterface

// File: rtl/sentinel_mem_writer.sv
// sentinel_mem_writer
//   Stores an incoming word stream at consecutive addresses from 0 and then
//   terminates it with a zero sentinel, so a sequential reader can walk the
//   memory until it sees 0. A data word of 0 is itself the terminator. The last
//   memory entry is reserved so a sentinel always fits.
//
//   Ports
//     clk        rising-edge clock
//     rst        asynchronous active-high reset (memory contents not reset)
//     bus        sentinel_mem_writer_if.slave: handshake, clear, read port, status
//     state_dbg  current FSM state (0 FILL, 1 TERM, 2 DONE)
module sentinel_mem_writer #(
    parameter int DEPTH  = 11,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    sentinel_mem_writer_if.slave  bus,
    output logic [1:0]            state_dbg
);

    localparam logic [1:0] ST_FILL = 2'd0;
    localparam logic [1:0] ST_TERM = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Highest address a data word may use plus one; entry DEPTH-1 is the
    // sentinel slot of a full memory.
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

    logic [1:0]        state;
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] count_q;
    logic              overflow_q;
    logic [DATA_W-1:0] rd_data_q;
    logic [DATA_W-1:0] mem [DEPTH];

    logic              accept;
    logic              is_zero;
    logic              wr_en;
    logic [DATA_W-1:0] wr_data;

    // Ready comes from registered state only; rst forces it low so nothing is
    // accepted while the block is held in reset.
    assign bus.in_ready = !rst && (state == ST_FILL) && (wr_ptr < LAST_IDX);
    assign accept       = bus.in_valid && bus.in_ready;
    assign is_zero      = (bus.in_data == '0);

    // One write port shared by data words (FILL) and the sentinel (TERM).
    // clear suppresses both, so a word offered together with clear is dropped.
    always_comb begin
        wr_en   = 1'b0;
        wr_data = bus.in_data;
        if (!bus.clear) begin
            if (state == ST_FILL && accept) begin
                wr_en = 1'b1;
            end else if (state == ST_TERM) begin
                wr_en   = 1'b1;
                wr_data = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Read happens with the pre-edge memory contents, so a same-address write
    // in the same cycle returns the old word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data_q <= '0;
        end else if (int'(bus.rd_addr) < DEPTH) begin
            rd_data_q <= mem[bus.rd_addr];
        end else begin
            rd_data_q <= '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_FILL;
            wr_ptr     <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else if (bus.clear) begin
            state      <= ST_FILL;
            wr_ptr     <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            case (state)
                ST_FILL: begin
                    if (accept) begin
                        if (is_zero) begin
                            // The stored zero terminates the stream in place.
                            state <= ST_DONE;
                        end else begin
                            wr_ptr  <= wr_ptr + ADDR_W'(1);
                            count_q <= count_q + ADDR_W'(1);
                            if (bus.in_last) begin
                                state <= ST_TERM;
                            end else if (wr_ptr + ADDR_W'(1) == LAST_IDX) begin
                                overflow_q <= 1'b1;
                                state      <= ST_TERM;
                            end
                        end
                    end
                end
                ST_TERM: state <= ST_DONE;
                ST_DONE: state <= ST_DONE;
                default: state <= ST_FILL;
            endcase
        end
    end

    assign bus.rd_data  = rd_data_q;
    assign bus.count    = count_q;
    assign bus.done     = (state == ST_DONE);
    assign bus.overflow = overflow_q;
    assign state_dbg    = state;

endmodule
